// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer for the 5-stage core: owns every stage-register
// write-enable/flush and resolves freeze, branch, load-use and halt/drain hazards.
module hazard_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1,
  input  logic [4:0]       IFID_RS2,
  input  logic             IFID_UsesRS2,
  input  logic [4:0]       IDEXE_RD,
  input  logic             IDEXE_MemRead,
  input  logic             Branch_Taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEXE_Write,
  output logic             IDEXE_Flush,
  output logic             EXEMEM_Write,
  output logic             MEMWB_Flush,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t     state;
  logic [2:0] drain_cnt;
  logic [7:0] wait_cnt;
  logic       freeze;
  logic       load_use;
  logic [8:0] wait_next;

  assign freeze    = dmem_req & ~dmem_ready;
  assign load_use  = IDEXE_MemRead && (IDEXE_RD != 5'd0) &&
                     ((IDEXE_RD == IFID_RS1) || (IFID_UsesRS2 && (IDEXE_RD == IFID_RS2)));
  assign wait_next = {1'b0, wait_cnt} + 9'd1;

  // Priority: freeze > taken branch > load-use (RUN only) > drain/halt bubbles.
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXE_Write  = 1'b1;
    IDEXE_Flush  = 1'b0;
    EXEMEM_Write = 1'b1;
    MEMWB_Flush  = 1'b0;
    if (freeze) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEXE_Write  = 1'b0;
      EXEMEM_Write = 1'b0;
      MEMWB_Flush  = 1'b1;
    end else begin
      if (state != RUN) begin
        PCWrite    = 1'b0;
        IFID_Flush = 1'b1;
      end
      if (Branch_Taken) begin
        PCWrite     = 1'b1;
        IFID_Flush  = 1'b1;
        IDEXE_Flush = 1'b1;
      end else if (state == RUN && load_use) begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEXE_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= RUN;
      drain_cnt     <= 3'(DRAIN_CYCLES);
      wait_cnt      <= '0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      mem_timeout_o <= 1'b0;
      halted_o      <= 1'b0;
    end else begin
      if (freeze) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 8'd1;
        // Flag becomes visible together with the count reaching the limit.
        if (wait_next >= 9'(MEM_TIMEOUT)) mem_timeout_o <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state == RUN && !PCWrite && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (!freeze && Branch_Taken && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);

      if (!freeze) begin
        case (state)
          RUN: begin
            if (halt_req_i) begin
              state     <= DRAIN;
              drain_cnt <= 3'(DRAIN_CYCLES);
            end
          end
          DRAIN: begin
            if (drain_cnt <= 3'd1) begin
              state    <= HALTED;
              halted_o <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 3'd1;
            end
          end
          HALTED: begin
            if (resume_i) begin
              state     <= RUN;
              halted_o  <= 1'b0;
              drain_cnt <= 3'(DRAIN_CYCLES);
            end
          end
          default: begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios followed by
// randomized traffic compared against a behavioural model of the control rules.
module tb_hazard_sequencer;
  localparam int unsigned DC = 3;
  localparam int unsigned MT = 4;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, uses_rs2, mem_read, br, req, rdy, halt, resume;
  logic [4:0] rs1, rs2, rd;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, halted, timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_sequencer #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS1(rs1), .IFID_RS2(rs2), .IFID_UsesRS2(uses_rs2),
    .IDEXE_RD(rd), .IDEXE_MemRead(mem_read), .Branch_Taken(br),
    .dmem_req(req), .dmem_ready(rdy), .halt_req_i(halt), .resume_i(resume),
    .PCWrite(pc_w), .IFID_Write(ifid_w), .IFID_Flush(ifid_f),
    .IDEXE_Write(idex_w), .IDEXE_Flush(idex_f), .EXEMEM_Write(exmem_w),
    .MEMWB_Flush(memwb_f), .halted_o(halted),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(timeout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=running, 1=draining, 2=halted.
  int m_mode, m_left, m_wait, m_stall, m_flush;
  bit m_to;

  task automatic model_reset();
    m_mode = 0; m_left = DC; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic idle_inputs();
    rst = 0; uses_rs2 = 0; mem_read = 0; br = 0; req = 0; rdy = 0;
    halt = 0; resume = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit fz, lu, run, e_pc, e_ifw, e_iff, e_idf;
    @(negedge clk);
    fz  = req && !rdy;
    run = (m_mode == 0);
    lu  = mem_read && rd != 0 && (rd == rs1 || (uses_rs2 && rd == rs2));
    e_pc  = fz ? 1'b0 : (br ? 1'b1 : (run && !lu));
    e_ifw = !fz && !(run && !br && lu);
    e_iff = !fz && (br || !run);
    e_idf = !fz && (br || (run && lu));
    check("ctl", {25'd0, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f},
          {25'd0, e_pc, e_ifw, e_iff, !fz, e_idf, !fz, fz});
    check("halted", {31'd0, halted}, (m_mode == 2) ? 1 : 0);
    check("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, m_stall);
    check("flush_cnt", {{(32-CW){1'b0}}, flush_cnt}, m_flush);
    check("mem_timeout", {31'd0, timeout}, {31'd0, m_to});
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (fz) begin
        m_wait = sat(m_wait + 1, 255);
        if (m_wait >= MT) m_to = 1;
      end else m_wait = 0;
      if (run && !e_pc) m_stall = sat(m_stall + 1, CMAX);
      if (!fz && br) m_flush = sat(m_flush + 1, CMAX);
      if (!fz) begin
        if (m_mode == 0 && halt) begin m_mode = 1; m_left = DC; end
        else if (m_mode == 1) begin
          if (m_left == 1) m_mode = 2; else m_left--;
        end else if (m_mode == 2 && resume) begin m_mode = 0; m_left = DC; end
      end
    end
    #1;
  endtask

  task automatic reset_tick();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    tick();
    check("reset_stall", {{(32-CW){1'b0}}, stall_cnt}, 0);

    // lw x5 ; add x6,x5,x7
    mem_read = 1; rd = 5; rs1 = 5; rs2 = 7; uses_rs2 = 1; tick();
    idle_inputs(); tick();
    check("lu_stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 1);

    // rs2 match without rs2 use, and x0 match: no stall
    mem_read = 1; rd = 5; rs1 = 1; rs2 = 5; uses_rs2 = 0; tick();
    rd = 0; rs1 = 0; tick();
    idle_inputs();
    check("no_stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 1);

    // branch overrides load-use
    reset_tick();
    mem_read = 1; rd = 5; rs1 = 5; br = 1; tick();
    idle_inputs(); tick();
    check("br_flush_cnt", {{(32-CW){1'b0}}, flush_cnt}, 1);
    check("br_stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 0);

    // freeze 5 cycles with a pending branch, branch resolves on cycle 6
    reset_tick();
    req = 1; rdy = 0; br = 1;
    repeat (5) tick();
    rdy = 1; tick();
    idle_inputs(); tick();
    check("frz_stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 5);
    check("frz_flush_cnt", {{(32-CW){1'b0}}, flush_cnt}, 1);

    // halt pulse, freeze mid-drain, then resume
    reset_tick();
    halt = 1; tick(); halt = 0;
    tick();
    req = 1; tick(); req = 0;
    tick();
    check("drain_not_yet", {31'd0, halted}, 0);
    tick();
    check("halted_rise", {31'd0, halted}, 1);
    tick();
    resume = 1; tick(); resume = 0;
    check("resumed", {31'd0, halted}, 0);
    tick();

    // memory timeout
    reset_tick();
    req = 1;
    repeat (3) tick();
    check("to_before", {31'd0, timeout}, 0);
    tick();
    check("to_set", {31'd0, timeout}, 1);
    repeat (2) tick();
    rdy = 1; tick();
    idle_inputs(); repeat (3) tick();
    check("to_sticky", {31'd0, timeout}, 1);
    reset_tick();
    check("to_cleared", {31'd0, timeout}, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      req      = ($urandom_range(0, 99) < 30);
      rdy      = ($urandom_range(0, 99) < 50);
      br       = ($urandom_range(0, 99) < 15);
      mem_read = ($urandom_range(0, 99) < 40);
      uses_rs2 = $urandom_range(0, 1);
      rd       = 5'($urandom_range(0, 3));
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      halt     = ($urandom_range(0, 99) < 10);
      resume   = ($urandom_range(0, 99) < 20);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
